reg_list_sequencer: RTL and testbench
=====================================

REG_LIST_SEQUENCER -- requirements
Module: reg_list_sequencer

Interface
REQ-001 Parameter: ADDR_STEP, default 4, byte increment between consecutive transfer addresses.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 START  input  1  request a block transfer; sampled only in IDLE.
REQ-005 REG_LIST  input  16  bit i set means register Ri takes part in the transfer; sampled with START.
REQ-006 BASE  input  32  base byte address; sampled with START.
REQ-007 UP  input  1  1 = ascending from BASE, 0 = descending below BASE; sampled with START.
REQ-008 LOAD  input  1  1 = memory-to-register, 0 = register-to-memory; sampled with START.
REQ-009 MEM_READY  input  1  memory accepts the current request this cycle.
REQ-010 ABORT  input  1  cancel the transfer in progress.
REQ-011 BUSY  output  1  high in CALC and XFER.
REQ-012 DONE  output  1  one-cycle completion pulse.
REQ-013 MEM_REQ  output  1  memory request valid.
REQ-014 MEM_WRITE  output  1  high with MEM_REQ when LOAD=0.
REQ-015 MEM_ADDR  output  32  byte address of the current transfer.
REQ-016 RF_A  output  4  register file read-port select, for stores.
REQ-017 RF_C  output  4  register file write-port select, for loads.
REQ-018 RF_WE  output  1  drives the register file write ENABLE.
REQ-019 WB_ADDR  output  32  write-back base: BASE plus ADDR_STEP*N if UP=1, BASE minus ADDR_STEP*N if UP=0; N = popcount(REG_LIST); valid from CALC onward.
REQ-020 COUNT  output  5  number of transfers completed in the current or most recent operation.

Function
REQ-021 States SHALL be IDLE, CALC, XFER and FIN; the state SHALL move from IDLE to CALC on START=1.
REQ-022 CALC SHALL last one cycle: latch N and WB_ADDR, and set the first address to BASE (UP=1) or BASE-ADDR_STEP*N (UP=0). The next state is XFER if N>0, else FIN.
REQ-023 Registers SHALL be transferred in ascending index order, so the lowest register always gets the lowest address, in both UP modes.
REQ-024 In XFER, MEM_REQ=1, and MEM_ADDR, MEM_WRITE, RF_A and RF_C SHALL stay stable until a cycle with MEM_READY=1.
REQ-025 A transfer SHALL complete in a cycle where MEM_REQ=1 and MEM_READY=1. On completion: COUNT increments, MEM_ADDR advances by ADDR_STEP, and the next set bit becomes current.
REQ-026 RF_WE SHALL be combinational LOAD&MEM_REQ&MEM_READY&~ABORT, so exactly one write happens per loaded register.
REQ-027 After the last transfer completes, the next state SHALL be FIN. FIN lasts one cycle with DONE=1 and BUSY=0, then returns to IDLE.
REQ-028 First MEM_REQ latency SHALL be 2 cycles after the START sample edge. With MEM_READY tied high, DONE SHALL assert N+2 cycles after that edge.
REQ-029 START outside IDLE SHALL be ignored; a new START is accepted only in IDLE.
REQ-030 ABORT=1 in CALC or XFER SHALL force IDLE at the next edge with no DONE pulse. The cycle in which ABORT is high SHALL not produce a write or a completed transfer. COUNT SHALL hold the transfers completed before ABORT.
REQ-031 An empty REG_LIST SHALL give CALC then FIN, with no MEM_REQ, COUNT=0 and WB_ADDR=BASE.
REQ-032 REG_LIST=16'hFFFF SHALL give 16 transfers and COUNT=16, using the 5-bit width.
REQ-033 Address arithmetic SHALL be modulo 2^32; wrap-around past 32'hFFFFFFFC or below 0 is legal and unflagged.
REQ-034 MEM_REQ, RF_WE and MEM_WRITE SHALL be 0 in IDLE and FIN.

Reset
REQ-035 RESET=0 SHALL force IDLE immediately. While RESET=0: BUSY=0, DONE=0, MEM_REQ=0, MEM_WRITE=0, RF_WE=0, MEM_ADDR=0, WB_ADDR=0, RF_A=0, RF_C=0, COUNT=0.
REQ-036 Reset during XFER SHALL drop MEM_REQ and RF_WE within the same cycle, and no DONE SHALL follow.

Structure
REQ-037 A shared package SHALL hold the state encoding (IDLE=0, CALC=1, XFER=2, FIN=3) and the ADDR_STEP default.
REQ-038 One sub-module, lowest_set_bit_16, SHALL provide a 16-bit priority encoder (index plus valid); the sequencer clears each bit as it is consumed.

Verification
REQ-039 REG_LIST=16'h0013, BASE=32'h100, UP=1, LOAD=1, MEM_READY=1 -> RF_C 0,1,4 at MEM_ADDR 100,104,108; 3 RF_WE pulses; WB_ADDR=10C; DONE at cycle 5.
REQ-040 REG_LIST=16'h8001, BASE=32'h200, UP=0, LOAD=0 -> RF_A 0 at 1F8, RF_A 15 at 1FC; MEM_WRITE=1; WB_ADDR=1F8.
REQ-041 MEM_READY low for 3 cycles on the second transfer of 16'h0006 -> MEM_ADDR and RF_C held for those cycles; COUNT=2 only after acceptance.
REQ-042 REG_LIST=0, BASE=32'h40 -> DONE 2 cycles after START; no MEM_REQ; WB_ADDR=40.
REQ-043 ABORT in the second XFER cycle of 16'h000F with MEM_READY=1 -> IDLE next cycle, COUNT=1, no DONE, no second RF_WE.
REQ-044 RESET=0 mid-XFER, then a START repeated while BUSY -> all outputs are 0 at once; the repeated START is ignored until IDLE.

Source files
------------

// File: rtl/reg_list_sequencer_pkg.sv
// Shared types and constants for the register-list block transfer sequencer.
// Holds the state encoding, the default address step and a popcount helper.
package reg_list_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_XFER = 2'd2,
        ST_FIN  = 2'd3
    } seq_state_t;

    localparam int unsigned ADDR_STEP_DEFAULT = 4;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/reg_list_sequencer_lowest_set_bit_16.sv
// 16-bit priority encoder: index of the lowest set bit, plus a valid flag.
module lowest_set_bit_16 (
    input  logic [15:0] i_vec,
    output logic [3:0]  o_idx,
    output logic        o_valid
);

    always_comb begin
        o_idx   = 4'd0;
        o_valid = |i_vec;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = 15; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/reg_list_sequencer.sv
// Walks a 16-bit register list, issuing one memory request per selected
// register in ascending index order, ascending or descending from a base.
module reg_list_sequencer
    import reg_list_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_STEP = ADDR_STEP_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_reg_list,
    input  logic [31:0] i_base,
    input  logic        i_up,
    input  logic        i_load,
    input  logic        i_mem_ready,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_mem_req,
    output logic        o_mem_write,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_rf_a,
    output logic [3:0]  o_rf_c,
    output logic        o_rf_we,
    output logic [31:0] o_wb_addr,
    output logic [4:0]  o_count
);

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    seq_state_t  r_state;
    logic [15:0] r_pending;
    logic [4:0]  r_n;
    logic [4:0]  r_count;
    logic [31:0] r_addr;
    logic [31:0] r_wb_addr;
    logic        r_load;

    logic [3:0]  w_idx;
    logic        w_valid;
    logic [4:0]  w_n;
    logic [31:0] w_span;
    logic        w_xfer;
    logic [15:0] w_pending_next;

    lowest_set_bit_16 u_lsb (
        .i_vec   (r_pending),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_n            = popcount16(i_reg_list);
    assign w_span         = STEP * {27'd0, w_n};
    assign w_xfer         = (r_state == ST_XFER);
    assign w_pending_next = r_pending & ~(16'd1 << w_idx);

    // Block geometry is captured at the START edge so WB_ADDR is already valid in CALC.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_n       <= '0;
            r_count   <= '0;
            r_addr    <= '0;
            r_wb_addr <= '0;
            r_load    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state   <= ST_CALC;
                        r_pending <= i_reg_list;
                        r_n       <= w_n;
                        r_count   <= '0;
                        r_load    <= i_load;
                        r_wb_addr <= i_up ? (i_base + w_span) : (i_base - w_span);
                        r_addr    <= i_up ? i_base : (i_base - w_span);
                    end
                end
                ST_CALC: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                    end else if (r_n == 5'd0) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_valid && i_mem_ready) begin
                        r_count   <= r_count + 5'd1;
                        r_addr    <= r_addr + STEP;
                        r_pending <= w_pending_next;
                        if (w_pending_next == 16'd0) begin
                            r_state <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = (r_state == ST_CALC) || w_xfer;
    assign o_done      = (r_state == ST_FIN);
    assign o_mem_req   = w_xfer;
    assign o_mem_write = w_xfer & ~r_load;
    assign o_rf_we     = r_load & w_xfer & i_mem_ready & ~i_abort;
    assign o_mem_addr  = r_addr;
    assign o_rf_a      = w_idx;
    assign o_rf_c      = w_idx;
    assign o_wb_addr   = r_wb_addr;
    assign o_count     = r_count;

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Self-checking bench for reg_list_sequencer: directed table, corner sequences
// and randomized operations checked against a list-based reference model.
module tb_reg_list_sequencer;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [15:0] i_reg_list;
    logic [31:0] i_base;
    logic        i_up;
    logic        i_load;
    logic        i_mem_ready;
    logic        i_abort;
    logic        o_busy;
    logic        o_done;
    logic        o_mem_req;
    logic        o_mem_write;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_rf_a;
    logic [3:0]  o_rf_c;
    logic        o_rf_we;
    logic [31:0] o_wb_addr;
    logic [4:0]  o_count;

    always #5 clk = ~clk;

    reg_list_sequencer #(.ADDR_STEP(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_reg_list  (i_reg_list),
        .i_base      (i_base),
        .i_up        (i_up),
        .i_load      (i_load),
        .i_mem_ready (i_mem_ready),
        .i_abort     (i_abort),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_mem_req   (o_mem_req),
        .o_mem_write (o_mem_write),
        .o_mem_addr  (o_mem_addr),
        .o_rf_a      (o_rf_a),
        .o_rf_c      (o_rf_c),
        .o_rf_we     (o_rf_we),
        .o_wb_addr   (o_wb_addr),
        .o_count     (o_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] list;
        logic [31:0] base;
        logic        up;
        logic        load;
        logic [31:0] wb;
        int          cnt;
        int          done;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},      32'(o_busy), 0);
        check({tag, " done"},      32'(o_done), 0);
        check({tag, " mem_req"},   32'(o_mem_req), 0);
        check({tag, " mem_write"}, 32'(o_mem_write), 0);
        check({tag, " rf_we"},     32'(o_rf_we), 0);
        check({tag, " mem_addr"},  o_mem_addr, 0);
        check({tag, " wb_addr"},   o_wb_addr, 0);
        check({tag, " rf_a"},      32'(o_rf_a), 0);
        check({tag, " rf_c"},      32'(o_rf_c), 0);
        check({tag, " count"},     32'(o_count), 0);
    endtask

    // mode: 0 = ready always, 1 = random ready, 2 = three stall cycles on the second transfer.
    // Reference: the selected indices in ascending order, placed at consecutive 4-byte slots
    // starting at base (up) or base-4N (down).
    task automatic run_op(input logic [15:0] list, input logic [31:0] base, input logic up,
                          input logic load, input int mode, input int abort_cyc,
                          output int done_cyc, output logic [31:0] wb_seen, output int count_seen);
        int          idx_q[$];
        int          n, k, stall, cyc;
        logic [31:0] first, wb;
        logic        rdy, ab, exp_req, exp_done, aborted;
        idx_q = {};
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                idx_q.push_back(i);
                n++;
            end
        end
        first    = up ? base : base - 32'(4 * n);
        wb       = up ? base + 32'(4 * n) : base - 32'(4 * n);
        done_cyc = -1;
        k        = 0;
        stall    = 0;
        aborted  = 1'b0;

        @(posedge clk); #1;
        check("idle_before_start", 32'(o_busy), 0);
        i_start = 1'b1; i_reg_list = list; i_base = base; i_up = up; i_load = load;
        i_mem_ready = 1'b1; i_abort = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_reg_list = 16'($urandom); i_base = $urandom; i_up = 1'($urandom); i_load = 1'($urandom);

        for (cyc = 1; cyc < 120; cyc++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 9) < 6);
                default: rdy = !(k == 1 && stall < 3);
            endcase
            ab = (cyc == abort_cyc);
            i_mem_ready = rdy;
            i_abort     = ab;
            #1;
            exp_req  = (cyc >= 2) && (k < n);
            exp_done = (cyc >= 2) && (k == n);
            check("mem_req",   32'(o_mem_req), 32'(exp_req));
            check("done",      32'(o_done), 32'(exp_done));
            check("busy",      32'(o_busy), 32'(!exp_done));
            check("count",     32'(o_count), 32'(k));
            check("mem_write", 32'(o_mem_write), 32'(exp_req && !load));
            check("rf_we",     32'(o_rf_we), 32'(load && exp_req && rdy && !ab));
            check("wb_addr",   o_wb_addr, wb);
            if (exp_req) begin
                check("mem_addr", o_mem_addr, first + 32'(4 * k));
                check("rf_sel", load ? 32'(o_rf_c) : 32'(o_rf_a), 32'(idx_q[k]));
                if (rdy && !ab) k++;
                else if (!ab) stall++;
            end
            if (exp_done) begin
                done_cyc = cyc;
                check("done_cycle", 32'(cyc), 32'(n + 2 + stall));
                break;
            end
            if (ab) begin
                aborted = 1'b1;
                @(posedge clk); #1;
                i_abort = 1'b0; i_mem_ready = 1'b1;
                #1;
                check("abort_busy",    32'(o_busy), 0);
                check("abort_mem_req", 32'(o_mem_req), 0);
                check("abort_count",   32'(o_count), 32'(k));
                for (int j = 0; j < 3; j++) begin
                    check("abort_no_done", 32'(o_done), 0);
                    @(posedge clk); #2;
                end
                break;
            end
            @(posedge clk); #1;
        end
        if (done_cyc < 0 && !aborted) check("done_timeout", 0, 1);
        i_mem_ready = 1'b1;
        i_abort     = 1'b0;
        wb_seen     = o_wb_addr;
        count_seen  = int'(o_count);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dc, cnt;
        logic [31:0] wbs;
        logic [15:0] rl;

        tbl[0] = '{16'h0013, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_010C, 3, 5};
        tbl[1] = '{16'h8001, 32'h0000_0200, 1'b0, 1'b0, 32'h0000_01F8, 2, 4};
        tbl[2] = '{16'h0000, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040, 0, 2};
        tbl[3] = '{16'hFFFF, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1040, 16, 18};
        tbl[4] = '{16'h0003, 32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_FFF8, 2, 4};
        tbl[5] = '{16'h0003, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_0004, 2, 4};
        tbl[6] = '{16'h0000, 32'h0000_0080, 1'b0, 1'b0, 32'h0000_0080, 0, 2};

        i_rst_n = 1'b0; i_start = 1'b0; i_reg_list = '0; i_base = '0;
        i_up = 1'b0; i_load = 1'b0; i_mem_ready = 1'b1; i_abort = 1'b0;
        #12;
        check_all_zero("reset");
        i_rst_n = 1'b1;

        for (int t = 0; t < 7; t++) begin
            run_op(tbl[t].list, tbl[t].base, tbl[t].up, tbl[t].load, 0, 0, dc, wbs, cnt);
            check($sformatf("tbl%0d wb", t),    wbs, tbl[t].wb);
            check($sformatf("tbl%0d count", t), 32'(cnt), 32'(tbl[t].cnt));
            check($sformatf("tbl%0d done", t),  32'(dc), 32'(tbl[t].done));
        end

        // Three-cycle stall on the second transfer.
        run_op(16'h0006, 32'h0000_0020, 1'b1, 1'b1, 2, 0, dc, wbs, cnt);
        check("stall done_cyc", 32'(dc), 32'd7);
        check("stall count", 32'(cnt), 32'd2);

        // Abort in the second XFER cycle.
        run_op(16'h000F, 32'h0000_0100, 1'b1, 1'b1, 0, 3, dc, wbs, cnt);
        check("abort count", 32'(cnt), 32'd1);
        check("abort no done", 32'(dc), 32'hFFFF_FFFF);

        // Reset in the middle of XFER.
        @(posedge clk); #1;
        i_start = 1'b1; i_reg_list = 16'h00FF; i_base = 32'h300; i_up = 1'b1; i_load = 1'b1;
        i_mem_ready = 1'b1;
        @(posedge clk); #1; i_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset mem_req", 32'(o_mem_req), 1);
        i_rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        check_all_zero("held_reset");
        i_rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            check("post_reset no done", 32'(o_done), 0);
            check("post_reset idle", 32'(o_busy), 0);
        end

        // START held high while busy must not restart the operation.
        i_start = 1'b1; i_reg_list = 16'h0003; i_base = 32'h500; i_up = 1'b1; i_load = 1'b0;
        i_mem_ready = 1'b0;
        @(posedge clk); #1;
        i_reg_list = 16'hFFFF; i_base = 32'h0; i_up = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 5) begin
                i_start = 1'b0;
                i_mem_ready = 1'b1;
            end
            #1;
            check("restart busy", 32'(o_busy), 1);
            check("restart mem_addr", o_mem_addr, 32'h500);
            check("restart wb", o_wb_addr, 32'h508);
            check("restart count", 32'(o_count), 0);
        end
        @(posedge clk); #1;
        check("restart second addr", o_mem_addr, 32'h504);
        check("restart write", 32'(o_mem_write), 1);
        @(posedge clk); #1;
        check("restart done", 32'(o_done), 1);
        check("restart final count", 32'(o_count), 2);

        // Randomized operations against the reference model.
        for (int r = 0; r < 30; r++) begin
            case ($urandom_range(0, 7))
                0:       rl = 16'h0000;
                1:       rl = 16'hFFFF;
                default: rl = 16'($urandom);
            endcase
            run_op(rl, $urandom, 1'($urandom), 1'($urandom), 1,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0, dc, wbs, cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
